// File: rtl/riio_pwr_pkg.sv
// -----------------------------------------------------------------------------
// riio_pwr_pkg
// Shared types and constants for the IO-ring supply-connection sequencer.
//
// Contents
//   pwr_seq_state_e : sequencer FSM state encoding
//   MAX_NCH         : largest supported number of connection channels
//   DEFAULT_SETTLE  : suggested settle_cyc value for integrators
// -----------------------------------------------------------------------------
package riio_pwr_pkg;

  // Upper bound on channels per supply domain.
  localparam int MAX_NCH = 16;

  // Reasonable settle window for a typical pad-ring switch; the actual value
  // is a run-time input, this is only a starting point for integration.
  localparam int DEFAULT_SETTLE = 4;

  // OFF     : all switches open, waiting for pwr_req
  // UP_STEP : close the next unmasked switch at or above idx
  // UP_WAIT : settle after closing a switch
  // ON      : all unmasked switches closed, pwr_ack asserted
  // DN_STEP : open the next switch at or below idx
  // DN_WAIT : settle after opening a switch
  typedef enum logic [2:0] {
    OFF     = 3'd0,
    UP_STEP = 3'd1,
    UP_WAIT = 3'd2,
    ON      = 3'd3,
    DN_STEP = 3'd4,
    DN_WAIT = 3'd5
  } pwr_seq_state_e;

endpackage

// File: rtl/riio_settle_cnt.sv
// -----------------------------------------------------------------------------
// riio_settle_cnt
// Settle-delay counter for the supply-connection sequencer. Loaded with the
// settle length when a switch changes, decremented while the sequencer waits,
// and reports done on the last wait cycle (count == 1).
//
// Ports
//   clk      : sequencing clock
//   rst_n    : async active-low reset, clears the count
//   load     : load load_val this cycle (takes priority over dec)
//   load_val : settle length, must already be >= 1
//   dec      : decrement by one; holds at zero, never wraps
//   done     : count equals one, i.e. this is the final wait cycle
// -----------------------------------------------------------------------------
module riio_settle_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/riio_conn_pwr_seq.sv
// -----------------------------------------------------------------------------
// riio_conn_pwr_seq
// Sequences NCH pad-ring supply-connection switches for one supply domain.
// Switches close in ascending index order on power-up and open in descending
// order on power-down, with a programmable settle delay after every switch
// change to limit inrush current. Masked channels are skipped without spending
// a settle window. kill forces an immediate disconnect and latches fault.
//
// Parameters
//   NCH      : number of connection channels (1..MAX_NCH)
//   CNT_W    : settle counter width
//   RST_CONN : reset/idle level of conn_en; 1 = always-on domain, ramp bypassed
//
// Ports
//   clk        : sequencing clock
//   rst_n      : async active-low reset (deassertion synchronised upstream)
//   pwr_req    : 1 = domain on, 0 = domain off
//   ch_mask    : 1 = channel skipped (never closed), sampled at each step
//   settle_cyc : wait cycles after each switch change, 0 behaves as 1
//   kill       : emergency disconnect, highest priority
//   conn_en    : registered switch enables
//   pwr_ack    : all unmasked channels closed and pwr_req = 1
//   busy       : ramp in progress (any state but OFF / ON)
//   fault      : sticky kill indication; cleared by kill = 0 with pwr_req = 0
// -----------------------------------------------------------------------------
module riio_conn_pwr_seq
  import riio_pwr_pkg::*;
#(
  parameter int   NCH      = 4,
  parameter int   CNT_W    = 8,
  parameter logic RST_CONN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwr_req,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [CNT_W-1:0] settle_cyc,
  input  logic             kill,
  output logic [NCH-1:0]   conn_en,
  output logic             pwr_ack,
  output logic             busy,
  output logic             fault
);

  // idx must be able to hold NCH itself: reaching NCH ends the up ramp.
  localparam int IDX_W = $clog2(NCH + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NCH);

  pwr_seq_state_e   state_q;
  logic [IDX_W-1:0] idx_q;
  logic [NCH-1:0]   conn_q;
  logic             ack_q;
  logic             busy_q;
  logic             fault_q;

  logic [CNT_W-1:0] settle_load;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_done;

  // Next channel to act on, found combinationally so that any run of masked
  // channels costs no cycles at all.
  logic             up_found;
  logic [IDX_W-1:0] up_sel;
  logic [NCH-1:0]   up_bit;
  logic             dn_found;
  logic [IDX_W-1:0] dn_sel;
  logic [NCH-1:0]   dn_bit;

  // A zero settle setting still gives one wait cycle per switch change.
  assign settle_load = (settle_cyc == '0) ? CNT_W'(1) : settle_cyc;

  // Up: lowest unmasked channel at or above idx.
  // Down: highest channel at or below idx that is unmasked or still closed;
  // a channel masked after it was closed must still be opened on the way down.
  // NOTE: every always_comb output gets a default first; a missed path would
  // otherwise infer a latch.
  always_comb begin
    up_found = 1'b0;
    up_sel   = '0;
    up_bit   = '0;
    dn_found = 1'b0;
    dn_sel   = '0;
    dn_bit   = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if ((IDX_W'(j) >= idx_q) && !ch_mask[j]) begin
        up_found = 1'b1;
        up_sel   = IDX_W'(j);
        up_bit   = '0;
        up_bit[j] = 1'b1;
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if ((IDX_W'(j) <= idx_q) && (!ch_mask[j] || conn_q[j])) begin
        dn_found = 1'b1;
        dn_sel   = IDX_W'(j);
        dn_bit   = '0;
        dn_bit[j] = 1'b1;
      end
    end
  end

  // The counter loads only when a step actually changes a switch, and counts
  // only while waiting; kill abandons any wait in progress.
  assign cnt_load = !kill && (((state_q == UP_STEP) && up_found) ||
                              ((state_q == DN_STEP) && dn_found));
  assign cnt_dec  = !kill && ((state_q == UP_WAIT) || (state_q == DN_WAIT));

  riio_settle_cnt #(
    .CNT_W (CNT_W)
  ) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (settle_load),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // Sequencer FSM with registered outputs. busy and pwr_ack are updated on
  // the same edge as the state they describe, so they never lag the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_CONN ? ON : OFF;
      idx_q   <= '0;
      conn_q  <= {NCH{RST_CONN}};
      ack_q   <= RST_CONN;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else if (kill) begin
      // Emergency disconnect: every switch opens at once, no ordered ramp.
      state_q <= OFF;
      idx_q   <= '0;
      conn_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b1;
    end else begin
      // fault is released only once the requester has also withdrawn pwr_req,
      // so a stale request cannot re-power the domain right after a kill.
      if (!pwr_req) begin
        fault_q <= 1'b0;
      end

      if (RST_CONN) begin
        // Always-on domain: switches stay closed unless a kill is pending.
        busy_q <= 1'b0;
        if (!fault_q) begin
          state_q <= ON;
          conn_q  <= '1;
          ack_q   <= 1'b1;
        end
      end else begin
        unique case (state_q)
          OFF: begin
            if (pwr_req && !fault_q) begin
              state_q <= UP_STEP;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end
          end

          UP_STEP: begin
            if (up_found) begin
              conn_q  <= conn_q | up_bit;
              idx_q   <= up_sel;
              state_q <= UP_WAIT;
            end else begin
              // Nothing left to close at or above idx.
              idx_q   <= IDX_END;
              state_q <= ON;
              ack_q   <= pwr_req;
              busy_q  <= 1'b0;
            end
          end

          UP_WAIT: begin
            // A reversal waits out the current settle window, then starts the
            // down walk at the switch that was just closed.
            if (cnt_done) begin
              if (pwr_req) begin
                idx_q   <= idx_q + 1'b1;
                state_q <= UP_STEP;
              end else begin
                state_q <= DN_STEP;
              end
            end
          end

          ON: begin
            ack_q <= pwr_req;
            if (!pwr_req) begin
              state_q <= DN_STEP;
              idx_q   <= IDX_LAST;
              busy_q  <= 1'b1;
            end
          end

          DN_STEP: begin
            if (dn_found) begin
              conn_q  <= conn_q & ~dn_bit;
              idx_q   <= dn_sel;
              state_q <= DN_WAIT;
            end else begin
              // Nothing left to open at or below idx.
              idx_q   <= '0;
              state_q <= OFF;
              busy_q  <= 1'b0;
            end
          end

          DN_WAIT: begin
            if (cnt_done) begin
              if (pwr_req) begin
                // Reversal: re-close from the switch that was just opened.
                state_q <= UP_STEP;
              end else if (idx_q == '0) begin
                state_q <= OFF;
                busy_q  <= 1'b0;
              end else begin
                idx_q   <= idx_q - 1'b1;
                state_q <= DN_STEP;
              end
            end
          end

          default: begin
            state_q <= OFF;
            idx_q   <= '0;
            conn_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign conn_en = conn_q;
  assign pwr_ack = ack_q;
  assign busy    = busy_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_riio_conn_pwr_seq.sv
// -----------------------------------------------------------------------------
// tb_riio_conn_pwr_seq
// Self-checking bench for riio_conn_pwr_seq (NCH = 4, CNT_W = 8).
// Expected conn_en changes (value and the clock edge they land on) are queued
// when stimulus is applied; a monitor pops and compares on every observed
// change. Status outputs are checked at computed cycles.
// -----------------------------------------------------------------------------
module tb_riio_conn_pwr_seq;
  import riio_pwr_pkg::*;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwr_req = 1'b0;
  logic [NCH-1:0]   ch_mask = '0;
  logic [CNT_W-1:0] settle_cyc = CNT_W'(DEFAULT_SETTLE);
  logic             kill = 1'b0;
  logic [NCH-1:0]   conn_en;
  logic             pwr_ack;
  logic             busy;
  logic             fault;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] val;
  } exp_t;

  exp_t           sb_q[$];
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_err = 0;
  logic           mon_en = 1'b0;
  logic [NCH-1:0] last_conn = '0;

  riio_conn_pwr_seq #(
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .RST_CONN (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwr_req    (pwr_req),
    .ch_mask    (ch_mask),
    .settle_cyc (settle_cyc),
    .kill       (kill),
    .conn_en    (conn_en),
    .pwr_ack    (pwr_ack),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Edge counter: a change caused by edge k is visible at the following
  // negedge while cyc == k.
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_conn(input int at, input logic [NCH-1:0] v);
    sb_q.push_back('{cyc: at, val: v});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard monitor: every conn_en change must match the next queued one.
  always @(negedge clk) begin : conn_mon
    exp_t e;
    if (mon_en && (conn_en !== last_conn)) begin
      if (sb_q.size() == 0) begin
        check("conn_unexpected", 32'(conn_en), 32'(last_conn));
      end else begin
        e = sb_q.pop_front();
        check("conn_val", 32'(conn_en), 32'(e.val));
        check("conn_cyc", cyc, e.cyc);
      end
      last_conn = conn_en;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    if (NCH > MAX_NCH) $fatal(1, "bench NCH out of range");

    // Reset state.
    @(negedge clk);
    check("rst_conn", 32'(conn_en), 32'h0);
    check("rst_ack", 32'(pwr_ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Full ramp up, no mask, settle 3: 4-cycle spacing, ack 17 after edge 0.
    wait_until(cyc + 2);
    t = cyc;
    settle_cyc = 8'd3;
    ch_mask    = 4'b0000;
    pwr_req    = 1'b1;
    expect_conn(t + 2,  4'b0001);
    expect_conn(t + 6,  4'b0011);
    expect_conn(t + 10, 4'b0111);
    expect_conn(t + 14, 4'b1111);
    wait_until(t + 3);
    check("up_busy", 32'(busy), 32'h1);
    wait_until(t + 17);
    check("up_ack_early", 32'(pwr_ack), 32'h0);
    wait_until(t + 18);
    check("up_ack", 32'(pwr_ack), 32'h1);
    check("on_busy", 32'(busy), 32'h0);

    // Ramp down from ON: ack drops on the first edge.
    wait_until(t + 20);
    t = cyc;
    pwr_req = 1'b0;
    expect_conn(t + 2,  4'b0111);
    expect_conn(t + 6,  4'b0011);
    expect_conn(t + 10, 4'b0001);
    expect_conn(t + 14, 4'b0000);
    wait_until(t + 1);
    check("dn_ack", 32'(pwr_ack), 32'h0);
    check("dn_busy", 32'(busy), 32'h1);
    wait_until(t + 16);
    check("dn_busy_last", 32'(busy), 32'h1);
    wait_until(t + 17);
    check("dn_off_busy", 32'(busy), 32'h0);

    // Masked channels 0 and 2, settle 2.
    wait_until(t + 20);
    t = cyc;
    ch_mask    = 4'b0101;
    settle_cyc = 8'd2;
    pwr_req    = 1'b1;
    expect_conn(t + 2, 4'b0010);
    expect_conn(t + 5, 4'b1010);
    wait_until(t + 7);
    check("mask_ack_early", 32'(pwr_ack), 32'h0);
    wait_until(t + 8);
    check("mask_ack", 32'(pwr_ack), 32'h1);
    check("mask_conn", 32'(conn_en), 32'hA);
    wait_until(t + 10);
    t = cyc;
    pwr_req = 1'b0;
    expect_conn(t + 2, 4'b0010);
    expect_conn(t + 5, 4'b0000);
    wait_until(t + 12);
    check("mask_dn_busy", 32'(busy), 32'h0);

    // Reversal during the settle window of ch2; ch1 gets masked meanwhile but
    // is closed, so it still opens on the way down.
    wait_until(t + 14);
    t = cyc;
    ch_mask    = 4'b0000;
    settle_cyc = 8'd3;
    pwr_req    = 1'b1;
    expect_conn(t + 2,  4'b0001);
    expect_conn(t + 6,  4'b0011);
    expect_conn(t + 10, 4'b0111);
    wait_until(t + 11);
    pwr_req = 1'b0;
    ch_mask = 4'b0010;
    expect_conn(t + 14, 4'b0011);
    expect_conn(t + 18, 4'b0001);
    expect_conn(t + 22, 4'b0000);
    wait_until(t + 24);
    check("rev_busy", 32'(busy), 32'h1);
    wait_until(t + 25);
    check("rev_off", 32'(busy), 32'h0);
    ch_mask = 4'b0000;

    // kill while conn_en = 0011.
    wait_until(t + 27);
    t = cyc;
    settle_cyc = 8'd3;
    pwr_req    = 1'b1;
    expect_conn(t + 2, 4'b0001);
    expect_conn(t + 6, 4'b0011);
    wait_until(t + 7);
    kill = 1'b1;
    expect_conn(t + 8, 4'b0000);
    wait_until(t + 8);
    check("kill_fault", 32'(fault), 32'h1);
    check("kill_ack", 32'(pwr_ack), 32'h0);
    check("kill_busy", 32'(busy), 32'h0);
    kill = 1'b0;
    wait_until(t + 14);
    check("fault_blocks", 32'(fault), 32'h1);
    check("fault_idle", 32'(busy), 32'h0);
    pwr_req = 1'b0;
    wait_until(t + 15);
    check("fault_clear", 32'(fault), 32'h0);
    // kill and pwr_req rising together: kill wins.
    kill    = 1'b1;
    pwr_req = 1'b1;
    wait_until(t + 16);
    check("kill_wins_fault", 32'(fault), 32'h1);
    check("kill_wins_busy", 32'(busy), 32'h0);
    kill    = 1'b0;
    pwr_req = 1'b0;
    wait_until(t + 17);
    check("fault_clear2", 32'(fault), 32'h0);

    // Fresh request after fault clears, settle 1.
    t = cyc;
    settle_cyc = 8'd1;
    pwr_req    = 1'b1;
    expect_conn(t + 2, 4'b0001);
    expect_conn(t + 4, 4'b0011);
    expect_conn(t + 6, 4'b0111);
    expect_conn(t + 8, 4'b1111);
    wait_until(t + 9);
    check("s1_ack_early", 32'(pwr_ack), 32'h0);
    wait_until(t + 10);
    check("s1_ack", 32'(pwr_ack), 32'h1);

    // settle 0 behaves as 1: ramp down, then up, then async reset mid-ramp.
    wait_until(t + 12);
    t = cyc;
    settle_cyc = 8'd0;
    pwr_req    = 1'b0;
    expect_conn(t + 2, 4'b0111);
    expect_conn(t + 4, 4'b0011);
    expect_conn(t + 6, 4'b0001);
    expect_conn(t + 8, 4'b0000);
    wait_until(t + 10);
    check("s0_dn_busy", 32'(busy), 32'h0);
    t = cyc;
    pwr_req = 1'b1;
    expect_conn(t + 2, 4'b0001);
    expect_conn(t + 4, 4'b0011);
    expect_conn(t + 6, 4'b0111);
    wait_until(t + 6);
    @(posedge clk);
    expect_conn(t + 7, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_conn", 32'(conn_en), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_ack", 32'(pwr_ack), 32'h0);
    pwr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
